serial_mod_checker: RTL and testbench

- Multi-channel serial divisibility checker: each channel consumes one bit per cycle of a binary number and tracks the running remainder modulo DIVISOR.
- Flags when the number accumulated so far is divisible by DIVISOR.
- Generalises the fixed divide-by-5 MSB-first detector: any divisor, N independent channels, runtime MSB-first/LSB-first mode, valid gating, per-channel clear, and remainder visibility.
- Sits between bit-serial deserialisers and the protocol checkers that need divisibility flags.

---
 rtl/serial_mod_pkg.sv | 25 ++
 rtl/serial_mod_checker_lane.sv | 96 +++++++++
 rtl/serial_mod_checker.sv | 50 +++++
 tb/tb_serial_mod_checker.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_mod_pkg.sv
// Shared types and arithmetic for the serial divisibility checker.
//   ch_state_t : per-channel state (no bits yet / number in progress)
//   mod_add    : (a + b) mod divisor for operands already below divisor,
//                reduced with one conditional subtract (no divider).
package serial_mod_pkg;

  typedef enum logic {
    CH_EMPTY  = 1'b0,
    CH_ACTIVE = 1'b1
  } ch_state_t;

  // Widest remainder the helper supports; callers zero-extend into it.
  localparam int MAX_RW = 16;

  function automatic logic [MAX_RW-1:0] mod_add(input logic [MAX_RW-1:0] a,
                                                input logic [MAX_RW-1:0] b,
                                                input logic [MAX_RW-1:0] divisor);
    logic [MAX_RW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    // a, b < divisor, so sum < 2*divisor: one subtract fully reduces it.
    if (sum >= {1'b0, divisor}) sum = sum - {1'b0, divisor};
    return sum[MAX_RW-1:0];
  endfunction

endpackage

// File: rtl/serial_mod_checker_lane.sv
// One channel of the serial divisibility checker.
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   in_valid    : accept din this cycle
//   din         : serial data bit
//   clear       : start a new number (combined with in_valid, din is its first bit)
//   lsb_first   : bit order, latched on the first bit of each number
//   out_valid   : registered copy of in_valid
//   dout        : number so far is divisible by DIVISOR
//   rem         : running remainder
module serial_mod_lane
  import serial_mod_pkg::*;
#(
  parameter int DIVISOR         = 5,
  parameter int REQUIRE_NONZERO = 1,
  parameter int RW              = $clog2(DIVISOR)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          din,
  input  logic          clear,
  input  logic          lsb_first,
  output logic          out_valid,
  output logic          dout,
  output logic [RW-1:0] rem
);

  localparam logic [RW-1:0] ONE = RW'(1);

  ch_state_t     state, state_nxt;
  logic [RW-1:0] rem_nxt;
  logic [RW-1:0] weight, weight_nxt;
  logic          seen_one, seen_one_nxt;
  logic          mode, mode_nxt;

  function automatic logic [RW-1:0] lane_add(input logic [RW-1:0] a,
                                             input logic [RW-1:0] b);
    return RW'(mod_add(MAX_RW'(a), MAX_RW'(b), MAX_RW'(DIVISOR)));
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CH_EMPTY;
      rem       <= '0;
      weight    <= ONE;
      seen_one  <= 1'b0;
      mode      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      rem       <= rem_nxt;
      weight    <= weight_nxt;
      seen_one  <= seen_one_nxt;
      mode      <= mode_nxt;
      out_valid <= in_valid;
    end
  end

  always_comb begin
    state_nxt    = state;
    rem_nxt      = rem;
    weight_nxt   = weight;
    seen_one_nxt = seen_one;
    mode_nxt     = mode;
    if (in_valid) begin
      if (state == CH_EMPTY || clear) begin
        // First bit of a new number; a concurrent clear discards the old one.
        mode_nxt     = lsb_first;
        rem_nxt      = RW'(din);
        weight_nxt   = lane_add(ONE, ONE);
        seen_one_nxt = din;
        state_nxt    = CH_ACTIVE;
      end else begin
        if (!mode) begin
          // MSB-first: shift left then add the new bit, reducing each step.
          rem_nxt = lane_add(lane_add(rem, rem), RW'(din));
        end else begin
          // LSB-first: add 2^k mod D for set bits, then advance the weight.
          rem_nxt    = din ? lane_add(rem, weight) : rem;
          weight_nxt = lane_add(weight, weight);
        end
        seen_one_nxt = seen_one | din;
      end
    end else if (clear) begin
      state_nxt    = CH_EMPTY;
      rem_nxt      = '0;
      weight_nxt   = ONE;
      seen_one_nxt = 1'b0;
    end
  end

  assign dout = (state == CH_ACTIVE) && (rem == '0) &&
                (seen_one || (REQUIRE_NONZERO == 0));

endmodule

// File: rtl/serial_mod_checker.sv
// Multi-channel serial divisibility checker. Each lane consumes one bit per
// accepted cycle and tracks the remainder of the number so far mod DIVISOR.
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   in_valid    : per-channel bit-accept strobe
//   din         : per-channel serial data bit
//   clear       : per-channel start of a new number
//   lsb_first   : bit order, latched per channel on its first bit
//   out_valid   : per-channel registered in_valid
//   dout        : per-channel divisible flag
//   rem         : packed remainders, channel i at [i*RW +: RW]
module serial_mod_checker
  import serial_mod_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int DIVISOR         = 5,
  parameter int REQUIRE_NONZERO = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [CHANNELS-1:0]                 in_valid,
  input  logic [CHANNELS-1:0]                 din,
  input  logic [CHANNELS-1:0]                 clear,
  input  logic                                lsb_first,
  output logic [CHANNELS-1:0]                 out_valid,
  output logic [CHANNELS-1:0]                 dout,
  output logic [CHANNELS*$clog2(DIVISOR)-1:0] rem
);

  localparam int RW = $clog2(DIVISOR);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    serial_mod_lane #(
      .DIVISOR         (DIVISOR),
      .REQUIRE_NONZERO (REQUIRE_NONZERO),
      .RW              (RW)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid[i]),
      .din       (din[i]),
      .clear     (clear[i]),
      .lsb_first (lsb_first),
      .out_valid (out_valid[i]),
      .dout      (dout[i]),
      .rem       (rem[i*RW +: RW])
    );
  end

endmodule

// File: tb/tb_serial_mod_checker.sv
// Directed bench for serial_mod_checker (4 channels, divisor 5). A second
// instance with REQUIRE_NONZERO=0 shares the inputs to cover all-zero numbers.
module tb_serial_mod_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        lsb_first;
  logic [3:0]  in_valid, din, clear;
  logic [3:0]  out_valid, dout, out_valid_z, dout_z;
  logic [11:0] rem, rem_z;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_mod_checker #(.CHANNELS(4), .DIVISOR(5), .REQUIRE_NONZERO(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .din(din), .clear(clear),
    .lsb_first(lsb_first), .out_valid(out_valid), .dout(dout), .rem(rem));

  serial_mod_checker #(.CHANNELS(4), .DIVISOR(5), .REQUIRE_NONZERO(0)) dut_z (
    .clk(clk), .reset(reset), .in_valid(in_valid), .din(din), .clear(clear),
    .lsb_first(lsb_first), .out_valid(out_valid_z), .dout(dout_z), .rem(rem_z));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 4'hF; din = 4'hF; clear = 4'h0; lsb_first = 1'b0;
    tick();
    n_checks++; if (out_valid !== 4'h0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0000", out_valid); end
    n_checks++; if (dout !== 4'h0) begin n_fail++; $display("FAIL reset_dout: got %b expected 0000", dout); end
    n_checks++; if (rem !== 12'h0) begin n_fail++; $display("FAIL reset_rem: got %h expected 000", rem); end
    n_checks++; if (dout_z !== 4'h0) begin n_fail++; $display("FAIL reset_dout_z: got %b expected 0000", dout_z); end
    reset = 1'b0; in_valid = 4'h0; din = 4'h0;
  endtask

  task automatic test_msb_first();
    int bits[4]  = '{1, 0, 1, 0};
    int erem[4]  = '{1, 2, 0, 0};
    int edout[4] = '{0, 0, 1, 1};
    lsb_first = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 4'b0001; din = {3'b000, bits[i][0]};
      tick();
      n_checks++; if (rem[2:0] !== 3'(erem[i])) begin n_fail++; $display("FAIL msb_rem bit%0d: got %0d expected %0d", i, rem[2:0], erem[i]); end
      n_checks++; if (dout[0] !== edout[i][0]) begin n_fail++; $display("FAIL msb_dout bit%0d: got %b expected %0d", i, dout[0], edout[i]); end
      n_checks++; if (out_valid !== 4'b0001) begin n_fail++; $display("FAIL msb_out_valid bit%0d: got %b expected 0001", i, out_valid); end
    end
    in_valid = 4'h0; din = 4'h0;
    tick();
    n_checks++; if (out_valid !== 4'h0) begin n_fail++; $display("FAIL msb_idle_out_valid: got %b expected 0000", out_valid); end
    n_checks++; if (dout[0] !== 1'b1) begin n_fail++; $display("FAIL msb_idle_dout: got %b expected 1", dout[0]); end
  endtask

  task automatic test_lsb_first();
    int bits[4]  = '{0, 1, 0, 1};
    int erem[4]  = '{0, 2, 2, 0};
    int edout[4] = '{0, 0, 0, 1};
    int bits2[3]  = '{1, 0, 1};
    int erem2[3]  = '{1, 1, 0};
    int edout2[3] = '{0, 0, 1};
    lsb_first = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 4'b0010; din = {2'b00, bits[i][0], 1'b0};
      tick();
      n_checks++; if (rem[5:3] !== 3'(erem[i])) begin n_fail++; $display("FAIL lsb_rem bit%0d: got %0d expected %0d", i, rem[5:3], erem[i]); end
      n_checks++; if (dout[1] !== edout[i][0]) begin n_fail++; $display("FAIL lsb_dout bit%0d: got %b expected %0d", i, dout[1], edout[i]); end
    end
    in_valid = 4'h0; din = 4'h0; clear = 4'b0010;
    tick();
    clear = 4'h0;
    n_checks++; if (rem[5:3] !== 3'd0) begin n_fail++; $display("FAIL lsb_clear_rem: got %0d expected 0", rem[5:3]); end
    n_checks++; if (dout[1] !== 1'b0) begin n_fail++; $display("FAIL lsb_clear_dout: got %b expected 0", dout[1]); end
    for (int i = 0; i < 3; i++) begin
      in_valid = 4'b0010; din = {2'b00, bits2[i][0], 1'b0};
      tick();
      n_checks++; if (rem[5:3] !== 3'(erem2[i])) begin n_fail++; $display("FAIL lsb5_rem bit%0d: got %0d expected %0d", i, rem[5:3], erem2[i]); end
      n_checks++; if (dout[1] !== edout2[i][0]) begin n_fail++; $display("FAIL lsb5_dout bit%0d: got %b expected %0d", i, dout[1], edout2[i]); end
    end
    in_valid = 4'h0; din = 4'h0;
  endtask

  task automatic test_require_nonzero();
    lsb_first = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 4'b0100; din = 4'h0;
      tick();
      n_checks++; if (rem[8:6] !== 3'd0) begin n_fail++; $display("FAIL zero_rem bit%0d: got %0d expected 0", i, rem[8:6]); end
      n_checks++; if (dout[2] !== 1'b0) begin n_fail++; $display("FAIL zero_dout_req bit%0d: got %b expected 0", i, dout[2]); end
      n_checks++; if (dout_z[2] !== 1'b1) begin n_fail++; $display("FAIL zero_dout_noreq bit%0d: got %b expected 1", i, dout_z[2]); end
    end
    in_valid = 4'b0100; din = 4'b0100;
    tick();
    n_checks++; if (rem[8:6] !== 3'd1) begin n_fail++; $display("FAIL zero_then_one_rem: got %0d expected 1", rem[8:6]); end
    n_checks++; if (dout[2] !== 1'b0) begin n_fail++; $display("FAIL zero_then_one_dout: got %b expected 0", dout[2]); end
    n_checks++; if (dout_z[2] !== 1'b0) begin n_fail++; $display("FAIL zero_then_one_dout_z: got %b expected 0", dout_z[2]); end
    in_valid = 4'h0; din = 4'h0;
  endtask

  task automatic test_long_stream();
    // (2^k - 1) mod 5 for k = 1,2,3,4 repeats with period 4.
    int cyc[4] = '{1, 3, 2, 0};
    lsb_first = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      in_valid = 4'b1000; din = 4'b1000;
      tick();
      n_checks++; if (rem[11:9] !== 3'(cyc[(k-1)%4])) begin n_fail++; $display("FAIL long_rem k=%0d: got %0d expected %0d", k, rem[11:9], cyc[(k-1)%4]); end
      n_checks++; if (dout[3] !== ((k % 4) == 0)) begin n_fail++; $display("FAIL long_dout k=%0d: got %b expected %0d", k, dout[3], ((k % 4) == 0)); end
    end
    in_valid = 4'h0; din = 4'h0;
  endtask

  task automatic test_clear_same_cycle();
    lsb_first = 1'b0; clear = 4'b0001;
    tick();
    clear = 4'h0;
    in_valid = 4'b0001; din = 4'b0001;
    tick();
    tick();
    n_checks++; if (rem[2:0] !== 3'd3) begin n_fail++; $display("FAIL clr_pre_rem: got %0d expected 3", rem[2:0]); end
    clear = 4'b0001; lsb_first = 1'b1; in_valid = 4'b0001; din = 4'b0001;
    tick();
    clear = 4'h0;
    n_checks++; if (rem[2:0] !== 3'd1) begin n_fail++; $display("FAIL clr_same_rem: got %0d expected 1", rem[2:0]); end
    n_checks++; if (dout[0] !== 1'b0) begin n_fail++; $display("FAIL clr_same_dout: got %b expected 0", dout[0]); end
    n_checks++; if (out_valid[0] !== 1'b1) begin n_fail++; $display("FAIL clr_same_out_valid: got %b expected 1", out_valid[0]); end
    // Mode input flips but the channel stays LSB-first: value 1 + 2 = 3, then 3.
    lsb_first = 1'b0; din = 4'b0001;
    tick();
    n_checks++; if (rem[2:0] !== 3'd3) begin n_fail++; $display("FAIL clr_mode_rem1: got %0d expected 3", rem[2:0]); end
    din = 4'b0000;
    tick();
    n_checks++; if (rem[2:0] !== 3'd3) begin n_fail++; $display("FAIL clr_mode_rem2: got %0d expected 3", rem[2:0]); end
    in_valid = 4'h0; din = 4'h0;
  endtask

  task automatic test_reset_mid();
    lsb_first = 1'b0; in_valid = 4'hF; din = 4'hF;
    tick();
    reset = 1'b1; clear = 4'hF;
    tick();
    reset = 1'b0; clear = 4'h0;
    n_checks++; if (out_valid !== 4'h0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b expected 0000", out_valid); end
    n_checks++; if (dout !== 4'h0) begin n_fail++; $display("FAIL rstmid_dout: got %b expected 0000", dout); end
    n_checks++; if (rem !== 12'h0) begin n_fail++; $display("FAIL rstmid_rem: got %h expected 000", rem); end
    in_valid = 4'b0001; din = 4'b0001;
    tick();
    n_checks++; if (rem !== 12'h001) begin n_fail++; $display("FAIL rstmid_restart_rem: got %h expected 001", rem); end
    n_checks++; if (out_valid !== 4'b0001) begin n_fail++; $display("FAIL rstmid_restart_out_valid: got %b expected 0001", out_valid); end
    in_valid = 4'h0; din = 4'h0;
  endtask

  task automatic test_parallel();
    logic [11:0] vpat[4];
    logic [11:0] dpat[4];
    logic [11:0] lpat;
    longint      mval[4];
    int          mk[4];
    bit          mst[4], mmode[4], mseen[4];
    int          er;
    bit          b;
    vpat[0] = 12'hFFF; vpat[1] = 12'h7FE; vpat[2] = 12'hEDB; vpat[3] = 12'hF3E;
    dpat[0] = 12'hB6D; dpat[1] = 12'h3C9; dpat[2] = 12'h5E7; dpat[3] = 12'hA53;
    lpat    = 12'hA5A;
    for (int ch = 0; ch < 4; ch++) begin
      mval[ch] = 0; mk[ch] = 0; mst[ch] = 0; mmode[ch] = 0; mseen[ch] = 0;
    end
    in_valid = 4'h0; din = 4'h0; clear = 4'hF;
    tick();
    clear = 4'h0;
    for (int c = 0; c < 12; c++) begin
      lsb_first = lpat[c];
      for (int ch = 0; ch < 4; ch++) begin
        in_valid[ch] = vpat[ch][c];
        din[ch]      = dpat[ch][c];
      end
      tick();
      for (int ch = 0; ch < 4; ch++) begin
        if (vpat[ch][c]) begin
          b = dpat[ch][c];
          if (!mst[ch]) begin
            mst[ch] = 1; mmode[ch] = lpat[c]; mval[ch] = longint'(b); mk[ch] = 1; mseen[ch] = b;
          end else begin
            if (!mmode[ch]) mval[ch] = mval[ch] * 2 + longint'(b);
            else            mval[ch] = mval[ch] + (longint'(b) << mk[ch]);
            mk[ch]++;
            mseen[ch] = mseen[ch] | b;
          end
        end
        er = int'(mval[ch] % 5);
        n_checks++; if (rem[ch*3 +: 3] !== 3'(er)) begin n_fail++; $display("FAIL par_rem c=%0d ch=%0d: got %0d expected %0d", c, ch, rem[ch*3 +: 3], er); end
        n_checks++; if (dout[ch] !== (mst[ch] && er == 0 && mseen[ch])) begin n_fail++; $display("FAIL par_dout c=%0d ch=%0d: got %b expected %0d", c, ch, dout[ch], (mst[ch] && er == 0 && mseen[ch])); end
        n_checks++; if (out_valid[ch] !== vpat[ch][c]) begin n_fail++; $display("FAIL par_out_valid c=%0d ch=%0d: got %b expected %b", c, ch, out_valid[ch], vpat[ch][c]); end
      end
    end
    in_valid = 4'h0; din = 4'h0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 4'h0; din = 4'h0; clear = 4'h0; lsb_first = 1'b0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_require_nonzero();
    test_long_stream();
    test_clear_same_cycle();
    test_reset_mid();
    test_parallel();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
